// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch sequencer. Owns the PC, reads a combinational-read
//   instruction memory and presents one registered instruction per cycle to
//   the decode stage over a valid/ready handshake. Supports stall, redirect
//   with flush, halt/drain, and counts accepted instructions.
//
// Ports
//   clk             in   1       clock, all state on rising edge
//   rst             in   1       synchronous reset, active-high
//   imem_addr       out  ADDR_W  word index to instruction memory (= pc)
//   imem_inst       in   32      instruction word at imem_addr, same cycle
//   redirect_valid  in   1       branch/jump taken or restart request
//   redirect_pc     in   ADDR_W  target word index for redirect
//   halt_req        in   1       external request to stop fetching
//   if_valid        out  1       if_inst/if_pc hold a valid instruction
//   if_inst         out  32      registered instruction to decode
//   if_pc           out  ADDR_W  word index of if_inst
//   if_ready        in   1       decode accepts when if_valid && if_ready
//   halted          out  1       fetch is stopped and drained
//   fetch_count     out  32      number of accepted instructions
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter logic [31:0]       HALT_INST = 32'h0000000C
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_r;
  logic [1:0]        state_r;

  logic [ADDR_W-1:0] pc_next_s;
  logic [1:0]        state_next_s;
  logic              valid_next_s;
  logic              load_s;
  logic              accept_s;
  logic              free_s;

  // Memory is addressed directly by the PC; the word comes back the same cycle.
  assign imem_addr = pc_r;

  // Next-state decode: redirect beats halt_req, which beats HALT_INST detection.
  always_comb begin
    accept_s     = if_valid && if_ready;
    free_s       = !if_valid || if_ready;
    pc_next_s    = pc_r;
    state_next_s = state_r;
    // Without a new load, the output word survives only if decode did not take it.
    valid_next_s = if_valid && !if_ready;
    load_s       = 1'b0;

    if (redirect_valid) begin
      // Flush: anything in the output register is dropped, even if accepted now.
      pc_next_s    = redirect_pc;
      valid_next_s = 1'b0;
      state_next_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (halt_req) begin
            state_next_s = DRAIN;
          end else if (free_s) begin
            load_s       = 1'b1;
            valid_next_s = 1'b1;
            pc_next_s    = pc_r + PC_ONE;
            // The halt word itself is still delivered; only later fetches stop.
            if (imem_inst == HALT_INST) begin
              state_next_s = DRAIN;
            end else begin
              state_next_s = RUN;
            end
          end else begin
            valid_next_s = 1'b1;
          end
        end
        DRAIN: begin
          if (free_s) begin
            state_next_s = HALTED;
            valid_next_s = 1'b0;
          end else begin
            state_next_s = DRAIN;
          end
        end
        HALTED: begin
          valid_next_s = 1'b0;
          state_next_s = HALTED;
        end
        default: begin
          valid_next_s = 1'b0;
          state_next_s = RUN;
        end
      endcase
    end
  end

  // State, PC and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      state_r     <= RUN;
      if_valid    <= 1'b0;
      if_inst     <= 32'h00000000;
      if_pc       <= {ADDR_W{1'b0}};
      fetch_count <= 32'h00000000;
      halted      <= 1'b0;
    end else begin
      pc_r     <= pc_next_s;
      state_r  <= state_next_s;
      if_valid <= valid_next_s;
      halted   <= (state_next_s == HALTED);
      if (load_s) begin
        if_inst <= imem_inst;
        if_pc   <= pc_r;
      end else begin
        if_inst <= if_inst;
        if_pc   <= if_pc;
      end
      // A handshake completed in a flush cycle still counts as delivered.
      if (accept_s) begin
        fetch_count <= fetch_count + 32'd1;
      end else begin
        fetch_count <= fetch_count;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl: directed scenarios followed by a
//   randomized run compared against a stream-level reference model.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int          AW   = 10;
  localparam logic [31:0] HALT = 32'h0000000C;

  logic          clk;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_inst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt_req;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [AW-1:0] if_pc;
  logic          if_ready;
  logic          halted;
  logic [31:0]   fetch_count;

  logic [31:0] mem [1024];
  int n_vec;
  int n_err;

  assign imem_inst = mem[imem_addr];

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .if_ready(if_ready), .halted(halted),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; if_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    n_vec++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h expected 0", if_inst); end
    n_vec++; if (if_pc !== 10'd0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", if_pc); end
    n_vec++; if (imem_addr !== 10'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
    n_vec++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h20020005; exp_w[1] = 32'h20070003; exp_w[2] = 32'h00e22025;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_inst !== exp_w[i] || if_pc !== AW'(i)) begin
        n_err++; $display("FAIL seq_word%0d: got v=%b inst=%h pc=%0d expected v=1 inst=%h pc=%0d", i, if_valid, if_inst, if_pc, exp_w[i], i);
      end
    end
    tick();
    n_vec++; if (fetch_count !== 32'd3) begin n_err++; $display("FAIL seq_count: got %0d expected 3", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    if_ready = 1'b1;
    tick(); tick();
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd1 || if_inst !== 32'h20070003 || imem_addr !== 10'd2) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b pc=%0d inst=%h addr=%0d expected v=1 pc=1 inst=20070003 addr=2", i, if_valid, if_pc, if_inst, imem_addr);
      end
    end
    if_ready = 1'b1;
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd2 || if_inst !== 32'h00e22025 || fetch_count !== 32'd2) begin
      n_err++; $display("FAIL stall_release: got v=%b pc=%0d inst=%h cnt=%0d expected v=1 pc=2 inst=00e22025 cnt=2", if_valid, if_pc, if_inst, fetch_count);
    end
  endtask

  task automatic test_redirect();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd6;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (if_valid !== 1'b0 || imem_addr !== 10'd6 || fetch_count !== 32'd2) begin
      n_err++; $display("FAIL redir_flush: got v=%b addr=%0d cnt=%0d expected v=0 addr=6 cnt=2", if_valid, imem_addr, fetch_count);
    end
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd6 || if_inst !== mem[6] || fetch_count !== 32'd2) begin
      n_err++; $display("FAIL redir_target: got v=%b pc=%0d inst=%h cnt=%0d expected v=1 pc=6 inst=%h cnt=2", if_valid, if_pc, if_inst, fetch_count, mem[6]);
    end
  endtask

  task automatic test_halt();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd4;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd4 || if_inst !== HALT || halted !== 1'b0 || imem_addr !== 10'd5) begin
      n_err++; $display("FAIL halt_deliver: got v=%b pc=%0d inst=%h h=%b addr=%0d expected v=1 pc=4 inst=%h h=0 addr=5", if_valid, if_pc, if_inst, halted, imem_addr, HALT);
    end
    if_ready = 1'b1;
    tick();
    n_vec++; if (if_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 10'd5 || fetch_count !== 32'd3) begin
      n_err++; $display("FAIL halt_stop: got v=%b h=%b addr=%0d cnt=%0d expected v=0 h=1 addr=5 cnt=3", if_valid, halted, imem_addr, fetch_count);
    end
    tick(); tick();
    n_vec++; if (if_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 10'd5) begin
      n_err++; $display("FAIL halt_idle: got v=%b h=%b addr=%0d expected v=0 h=1 addr=5", if_valid, halted, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 10'd0;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (halted !== 1'b0 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_exit: got h=%b v=%b expected h=0 v=0", halted, if_valid);
    end
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd0 || if_inst !== 32'h20020005) begin
      n_err++; $display("FAIL halt_restart: got v=%b pc=%0d inst=%h expected v=1 pc=0 inst=20020005", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_wrap();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd1023;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd1023 || if_inst !== mem[1023]) begin
      n_err++; $display("FAIL wrap_top: got v=%b pc=%0d inst=%h expected v=1 pc=1023 inst=%h", if_valid, if_pc, if_inst, mem[1023]);
    end
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd0 || if_inst !== 32'h20020005) begin
      n_err++; $display("FAIL wrap_zero: got v=%b pc=%0d inst=%h expected v=1 pc=0 inst=20020005", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_mid_reset();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd5;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd5) begin
      n_err++; $display("FAIL mrst_pre: got v=%b pc=%0d expected v=1 pc=5", if_valid, if_pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (if_valid !== 1'b0 || imem_addr !== 10'd0 || fetch_count !== 32'd0 || halted !== 1'b0) begin
      n_err++; $display("FAIL mrst_state: got v=%b addr=%0d cnt=%0d h=%b expected v=0 addr=0 cnt=0 h=0", if_valid, imem_addr, fetch_count, halted);
    end
    tick();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 10'd0 || if_inst !== 32'h20020005) begin
      n_err++; $display("FAIL mrst_first: got v=%b pc=%0d inst=%h expected v=1 pc=0 inst=20020005", if_valid, if_pc, if_inst);
    end
  endtask

  // Stream model: which word must be on the output, where fetch resumes,
  // whether fetch has been told to stop, and whether the stop has drained.
  task automatic test_random();
    logic          m_valid, m_stopped, m_halted, acc, rdy, rdir, hreq;
    logic [AW-1:0] m_out_pc, m_fetch, tgt;
    logic [31:0]   m_cnt;
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 7) == 0) ? HALT : ($urandom | 32'h80000000);
    do_reset();
    m_valid = 1'b0; m_stopped = 1'b0; m_halted = 1'b0;
    m_out_pc = '0; m_fetch = '0; m_cnt = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_vec++; if (if_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, if_valid, m_valid); end
      if (m_valid) begin
        n_vec++; if (if_pc !== m_out_pc || if_inst !== mem[m_out_pc]) begin
          n_err++; $display("FAIL rnd_word@%0d: got pc=%0d inst=%h expected pc=%0d inst=%h", cyc, if_pc, if_inst, m_out_pc, mem[m_out_pc]);
        end
      end
      n_vec++; if (imem_addr !== m_fetch) begin n_err++; $display("FAIL rnd_addr@%0d: got %0d expected %0d", cyc, imem_addr, m_fetch); end
      n_vec++; if (halted !== m_halted) begin n_err++; $display("FAIL rnd_halted@%0d: got %b expected %b", cyc, halted, m_halted); end
      n_vec++; if (fetch_count !== m_cnt) begin n_err++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, fetch_count, m_cnt); end

      rdy  = ($urandom_range(0, 9) < 7);
      rdir = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      hreq = ($urandom_range(0, 24) == 0);
      tgt  = ($urandom_range(0, 3) == 0) ? AW'(1020 + $urandom_range(0, 3)) : AW'($urandom_range(0, 1023));
      if_ready = rdy; redirect_valid = rdir; redirect_pc = tgt; halt_req = hreq;

      acc = m_valid && rdy;
      if (acc) m_cnt = m_cnt + 32'd1;
      if (rdir) begin
        m_valid = 1'b0; m_fetch = tgt; m_stopped = 1'b0; m_halted = 1'b0;
      end else if (m_stopped) begin
        if (!m_valid || acc) begin m_valid = 1'b0; m_halted = 1'b1; end
      end else if (hreq) begin
        m_stopped = 1'b1; m_valid = m_valid && !rdy;
      end else if (!m_valid || rdy) begin
        m_out_pc = m_fetch; m_valid = 1'b1; m_fetch = m_fetch + 10'd1;
        if (mem[m_out_pc] == HALT) m_stopped = 1'b1;
      end
      tick();
    end
    redirect_valid = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; if_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h10000000 | i;
    mem[0] = 32'h20020005; mem[1] = 32'h20070003; mem[2] = 32'h00e22025; mem[4] = HALT;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
